// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity encodings, FSM state
// encodings, baud-generator widths and the elaboration-time helper functions.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int SAMPLE_BITS = 4;   // 16 sample ticks per bit
    localparam int ACC_BITS    = 16;  // phase accumulator width

    // One-hot bit positions of the RX and TX state vectors
    localparam int RX_IDLE = 0, RX_START = 1, RX_DATA = 2, RX_PARITY = 3, RX_STOP = 4;
    localparam int TX_IDLE = 0, TX_START = 1, TX_DATA = 2, TX_PARITY = 3, TX_STOP = 4;

    typedef enum logic [4:0] {
        RX_S_IDLE   = 5'(1 << RX_IDLE),
        RX_S_START  = 5'(1 << RX_START),
        RX_S_DATA   = 5'(1 << RX_DATA),
        RX_S_PARITY = 5'(1 << RX_PARITY),
        RX_S_STOP   = 5'(1 << RX_STOP)
    } rx_state_t;

    typedef enum logic [4:0] {
        TX_S_IDLE   = 5'(1 << TX_IDLE),
        TX_S_START  = 5'(1 << TX_START),
        TX_S_DATA   = 5'(1 << TX_DATA),
        TX_S_PARITY = 5'(1 << TX_PARITY),
        TX_S_STOP   = 5'(1 << TX_STOP)
    } tx_state_t;

    // round(baud * 16 * 2^16 / clock); 64-bit math avoids overflow
    function automatic longint baud_increment(input longint clock_freq, input longint baud_rate);
        longint num;
        num = baud_rate * (longint'(1) << (SAMPLE_BITS + ACC_BITS));
        return (num + clock_freq / 2) / clock_freq;
    endfunction

    // Parity bit to transmit / expect for a zero-extended data word
    function automatic logic parity_bit(input logic [7:0] data, input int parity);
        return (parity == PAR_EVEN) ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_param_fifo.sv
// Synchronous FIFO with a registered head output. The head register is
// loaded directly on a push into an (effectively) empty FIFO, otherwise it
// is refreshed from storage by a registered read when the head is popped.
module uart_param_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty_out,
    output logic             full_out
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_inc, count;
    logic [WIDTH-1:0]    head_reg;

    assign count      = wr_ptr_reg - rd_ptr_reg;
    assign rd_ptr_inc = rd_ptr_reg + ONE;
    assign empty_out  = (count == '0);
    assign full_out   = count[DEPTH_LOG2];
    assign data_out   = head_reg;

    // Storage write port
    always_ff @(posedge clk_in) begin
        if (push_in)
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= data_in;
    end

    // Read/write pointers, extra MSB distinguishes full from empty
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_in) wr_ptr_reg <= wr_ptr_reg + ONE;
            if (pop_in)  rd_ptr_reg <= rd_ptr_inc;
        end
    end

    // Head register: bypass when the pushed word becomes the head
    always_ff @(posedge clk_in) begin
        if (rst_in)
            head_reg <= '0;
        else if (push_in && (empty_out || (pop_in && count == ONE)))
            head_reg <= data_in;
        else if (pop_in && count > ONE)
            head_reg <= mem[rd_ptr_inc[DEPTH_LOG2-1:0]];
    end

endmodule

// File: rtl/uart_param.sv
// Parametrised UART: fractional baud generator, 16x oversampled receiver
// with sticky errors, and transmitter with configurable frame format.
// Define UART_PARAM_RX_FIFO_EN to buffer received bytes in a FIFO;
// otherwise a single holding register is used.
module uart_param
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ   = 12_500_000,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int RX_FIFO_LOG2 = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       send_in,
    output logic       tx_ready_out,
    output logic       txd_out,
    input  logic       rxd_in,
    output logic [7:0] data_out,
    output logic       rx_valid_out,
    input  logic       rx_read_in,
    input  logic       err_clr_in,
    output logic       frame_err_out,
    output logic       parity_err_out,
    output logic       overrun_err_out
);
    localparam longint INC_L = baud_increment(longint'(CLOCK_FREQ), longint'(BAUD_RATE));
    localparam logic [ACC_BITS-1:0] BAUD_INC = INC_L[ACC_BITS-1:0];
    localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       STOP2     = (STOP_BITS == 2);

    generate
        if (INC_L <= 0 || INC_L >= (longint'(1) << ACC_BITS)) begin : g_bad_baud
            $error("uart_param: baud increment out of range");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
            RX_FIFO_LOG2 < 1 ||
            !(PARITY == PAR_NONE || PARITY == PAR_ODD || PARITY == PAR_EVEN)) begin : g_bad_cfg
            $error("uart_param: unsupported frame configuration");
        end
    endgenerate

    logic [ACC_BITS-1:0]    acc_reg;
    logic [ACC_BITS:0]      acc_sum;
    logic                   tick, bit_tick;
    logic [SAMPLE_BITS-1:0] tick_cnt_reg;

    assign acc_sum  = {1'b0, acc_reg} + {1'b0, BAUD_INC};
    assign tick     = acc_sum[ACC_BITS];
    assign bit_tick = tick && (&tick_cnt_reg);

    // Phase accumulator and free-running sample-tick counter
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_reg      <= '0;
            tick_cnt_reg <= '0;
        end else begin
            acc_reg <= acc_sum[ACC_BITS-1:0];
            if (tick) tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    logic rxd_meta_reg, rxd_sync_reg;

    // Two-flop synchroniser for the asynchronous RxD line
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rxd_meta_reg <= 1'b1;
            rxd_sync_reg <= 1'b1;
        end else begin
            rxd_meta_reg <= rxd_in;
            rxd_sync_reg <= rxd_meta_reg;
        end
    end

    rx_state_t              rx_state_reg, rx_state_next;
    logic [SAMPLE_BITS-1:0] rx_phase_reg, rx_phase_next;
    logic [2:0]             rx_bit_reg, rx_bit_next;
    logic [7:0]             rx_data_reg, rx_data_next;
    logic                   rx_brk_reg, rx_brk_next;
    logic                   rx_mid, rx_push, frame_set, parity_set, overrun_set;

    assign rx_mid = tick && (tick_cnt_reg == rx_phase_reg);

    // RX state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_state_reg <= RX_S_IDLE;
            rx_phase_reg <= '0;
            rx_bit_reg   <= '0;
            rx_data_reg  <= '0;
            rx_brk_reg   <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_phase_reg <= rx_phase_next;
            rx_bit_reg   <= rx_bit_next;
            rx_data_reg  <= rx_data_next;
            rx_brk_reg   <= rx_brk_next;
        end
    end

    // RX next-state: mid-bit sampling at the phase recorded on the start edge
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_phase_next = rx_phase_reg;
        rx_bit_next   = rx_bit_reg;
        rx_data_next  = rx_data_reg;
        rx_brk_next   = rx_brk_reg;
        rx_push       = 1'b0;
        frame_set     = 1'b0;
        parity_set    = 1'b0;
        unique case (rx_state_reg)
            RX_S_IDLE: if (tick && !rxd_sync_reg) begin
                rx_phase_next = tick_cnt_reg + 4'd8;
                rx_state_next = RX_S_START;
            end
            RX_S_START: if (rx_mid) begin
                if (rxd_sync_reg) begin
                    rx_state_next = RX_S_IDLE;
                end else begin
                    rx_state_next = RX_S_DATA;
                    rx_bit_next   = '0;
                    rx_data_next  = '0;
                end
            end
            RX_S_DATA: if (rx_mid) begin
                rx_data_next[rx_bit_reg] = rxd_sync_reg;
                rx_bit_next = rx_bit_reg + 3'd1;
                if (rx_bit_reg == LAST_BIT)
                    rx_state_next = (PARITY != PAR_NONE) ? RX_S_PARITY : RX_S_STOP;
            end
            RX_S_PARITY: if (rx_mid) begin
                parity_set    = (rxd_sync_reg != parity_bit(rx_data_reg, PARITY));
                rx_state_next = RX_S_STOP;
            end
            RX_S_STOP: begin
                if (rx_brk_reg) begin
                    // Line held low past the stop bit: wait for it to recover
                    if (rxd_sync_reg) begin
                        rx_brk_next   = 1'b0;
                        rx_state_next = RX_S_IDLE;
                    end
                end else if (rx_mid) begin
                    rx_push = 1'b1;
                    if (!rxd_sync_reg) begin
                        frame_set   = 1'b1;
                        rx_brk_next = 1'b1;
                    end else begin
                        rx_state_next = RX_S_IDLE;
                    end
                end
            end
            default: rx_state_next = RX_S_IDLE;
        endcase
    end

`ifdef UART_PARAM_RX_FIFO_EN
    logic fifo_empty, fifo_full, fifo_push, fifo_pop;

    assign fifo_pop     = rx_read_in && !fifo_empty;
    assign fifo_push    = rx_push && (!fifo_full || fifo_pop);
    assign overrun_set  = rx_push && fifo_full && !fifo_pop;
    assign rx_valid_out = !fifo_empty;

    uart_param_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (RX_FIFO_LOG2)
    ) u_rx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_in   (fifo_push),
        .data_in   (rx_data_reg),
        .pop_in    (fifo_pop),
        .data_out  (data_out),
        .empty_out (fifo_empty),
        .full_out  (fifo_full)
    );
`else
    logic [7:0] hold_reg;
    logic       hold_valid_reg;

    assign overrun_set  = rx_push && hold_valid_reg && !rx_read_in;
    assign rx_valid_out = hold_valid_reg;
    assign data_out     = hold_reg;

    // Holding register: an unread byte is kept unless popped in the same cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
        end else if (rx_push && (!hold_valid_reg || rx_read_in)) begin
            hold_reg       <= rx_data_reg;
            hold_valid_reg <= 1'b1;
        end else if (rx_read_in) begin
            hold_valid_reg <= 1'b0;
        end
    end
`endif

    logic frame_err_reg, parity_err_reg, overrun_err_reg;

    assign frame_err_out   = frame_err_reg;
    assign parity_err_out  = parity_err_reg;
    assign overrun_err_out = overrun_err_reg;

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frame_err_reg   <= 1'b0;
            parity_err_reg  <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            frame_err_reg   <= frame_set   || (frame_err_reg   && !err_clr_in);
            parity_err_reg  <= parity_set  || (parity_err_reg  && !err_clr_in);
            overrun_err_reg <= overrun_set || (overrun_err_reg && !err_clr_in);
        end
    end

    tx_state_t  tx_state_reg, tx_state_next;
    logic       tx_pend_reg, tx_pend_next;
    logic [7:0] tx_data_reg, tx_data_next;
    logic [2:0] tx_bit_reg, tx_bit_next, tx_bit_inc;
    logic       tx_stop_reg, tx_stop_next;
    logic       txd_reg, txd_next;
    logic       tx_ready;

    assign tx_ready     = (tx_state_reg == TX_S_IDLE) && !tx_pend_reg;
    assign tx_ready_out = tx_ready;
    assign txd_out      = txd_reg;
    assign tx_bit_inc   = tx_bit_reg + 3'd1;

    // TX state register; txd is registered so it is glitch-free
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_state_reg <= TX_S_IDLE;
            tx_pend_reg  <= 1'b0;
            tx_data_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_stop_reg  <= 1'b0;
            txd_reg      <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_pend_reg  <= tx_pend_next;
            tx_data_reg  <= tx_data_next;
            tx_bit_reg   <= tx_bit_next;
            tx_stop_reg  <= tx_stop_next;
            txd_reg      <= txd_next;
        end
    end

    // TX next-state: each bit tick ends the current bit and loads the next
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_pend_next  = tx_pend_reg;
        tx_data_next  = tx_data_reg;
        tx_bit_next   = tx_bit_reg;
        tx_stop_next  = tx_stop_reg;
        txd_next      = txd_reg;
        unique case (tx_state_reg)
            TX_S_IDLE: begin
                if (send_in && tx_ready) begin
                    tx_pend_next = 1'b1;
                    tx_data_next = data_in & DATA_MASK;
                end else if (tx_pend_reg && bit_tick) begin
                    tx_pend_next  = 1'b0;
                    tx_state_next = TX_S_START;
                    txd_next      = 1'b0;
                end
            end
            TX_S_START: if (bit_tick) begin
                tx_state_next = TX_S_DATA;
                tx_bit_next   = '0;
                txd_next      = tx_data_reg[0];
            end
            TX_S_DATA: if (bit_tick) begin
                if (tx_bit_reg == LAST_BIT) begin
                    tx_stop_next = 1'b0;
                    if (PARITY != PAR_NONE) begin
                        tx_state_next = TX_S_PARITY;
                        txd_next      = parity_bit(tx_data_reg, PARITY);
                    end else begin
                        tx_state_next = TX_S_STOP;
                        txd_next      = 1'b1;
                    end
                end else begin
                    tx_bit_next = tx_bit_inc;
                    txd_next    = tx_data_reg[tx_bit_inc];
                end
            end
            TX_S_PARITY: if (bit_tick) begin
                tx_state_next = TX_S_STOP;
                txd_next      = 1'b1;
            end
            TX_S_STOP: if (bit_tick) begin
                if (STOP2 && !tx_stop_reg)
                    tx_stop_next = 1'b1;
                else
                    tx_state_next = TX_S_IDLE;
            end
            default: tx_state_next = TX_S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_param.sv
// Directed testbench for uart_param: default-rate TX timing, loopback with
// 7E2 framing, parity/frame errors, glitch rejection and RX overrun.
module tb_uart_param;

    localparam int FAST_CLK  = 1_000_000;
    localparam int FAST_BAUD = 31_250;   // exactly 32 clocks per bit
    localparam int BITC      = 32;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_in;
    int   vectors = 0;
    int   miscompares = 0;

    // Default instance (12.5 MHz / 9600, 8N1)
    logic [7:0] d_data_in, d_data_out;
    logic d_send, d_ready, d_txd, d_valid, d_read, d_clr, d_fe, d_pe, d_oe;
    // Loopback instance (7E2)
    logic [7:0] l_data_in, l_data_out;
    logic l_send, l_ready, l_txd, l_valid, l_read, l_clr, l_fe, l_pe, l_oe;
    // Odd-parity receiver
    logic [7:0] o_data_out;
    logic o_txd, o_ready, o_valid, o_read, o_clr, o_fe, o_pe, o_oe, o_rxd;
    // 8N1 receiver with 4-entry FIFO when enabled
    logic [7:0] f_data_out;
    logic f_txd, f_ready, f_valid, f_read, f_clr, f_fe, f_pe, f_oe, f_rxd;

    logic line, sel;
    assign o_rxd = (sel == 1'b0) ? line : 1'b1;
    assign f_rxd = (sel == 1'b1) ? line : 1'b1;

    uart_param u_def (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(d_data_in), .send_in(d_send),
        .tx_ready_out(d_ready), .txd_out(d_txd), .rxd_in(1'b1), .data_out(d_data_out),
        .rx_valid_out(d_valid), .rx_read_in(d_read), .err_clr_in(d_clr),
        .frame_err_out(d_fe), .parity_err_out(d_pe), .overrun_err_out(d_oe));

    uart_param #(.CLOCK_FREQ(FAST_CLK), .BAUD_RATE(FAST_BAUD), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(2)) u_lb (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(l_data_in), .send_in(l_send),
        .tx_ready_out(l_ready), .txd_out(l_txd), .rxd_in(l_txd), .data_out(l_data_out),
        .rx_valid_out(l_valid), .rx_read_in(l_read), .err_clr_in(l_clr),
        .frame_err_out(l_fe), .parity_err_out(l_pe), .overrun_err_out(l_oe));

    uart_param #(.CLOCK_FREQ(FAST_CLK), .BAUD_RATE(FAST_BAUD), .PARITY(1)) u_odd (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(8'h00), .send_in(1'b0),
        .tx_ready_out(o_ready), .txd_out(o_txd), .rxd_in(o_rxd), .data_out(o_data_out),
        .rx_valid_out(o_valid), .rx_read_in(o_read), .err_clr_in(o_clr),
        .frame_err_out(o_fe), .parity_err_out(o_pe), .overrun_err_out(o_oe));

    uart_param #(.CLOCK_FREQ(FAST_CLK), .BAUD_RATE(FAST_BAUD), .RX_FIFO_LOG2(2)) u_fifo (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(8'h00), .send_in(1'b0),
        .tx_ready_out(f_ready), .txd_out(f_txd), .rxd_in(f_rxd), .data_out(f_data_out),
        .rx_valid_out(f_valid), .rx_read_in(f_read), .err_clr_in(f_clr),
        .frame_err_out(f_fe), .parity_err_out(f_pe), .overrun_err_out(f_oe));

    // Drive n serial bits, LSB of 'bits' first, one bit per BITC clocks
    task automatic drive_frame(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            line = bits[i];
            repeat (BITC) @(negedge clk_in);
        end
        line = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (4) @(negedge clk_in);
        rst_in = 1'b0;
        vectors++; if (d_txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b expected 1", d_txd); end
        vectors++; if (d_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", d_ready); end
        vectors++; if (d_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", d_valid); end
        vectors++; if (d_data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", d_data_out); end
        vectors++; if ({d_fe, d_pe, d_oe} !== 3'b000) begin miscompares++; $display("FAIL reset_errs: got %b expected 000", {d_fe, d_pe, d_oe}); end
        $display("reset: outputs checked");
    endtask

    task automatic test_tx_55();
        int   w;
        logic lvl;
        @(negedge clk_in); d_data_in = 8'h55; d_send = 1'b1;
        @(negedge clk_in); d_send = 1'b0;
        vectors++; if (d_ready !== 1'b0) begin miscompares++; $display("FAIL tx_ready_drop: got %b expected 0", d_ready); end
        w = 0;
        while (d_txd === 1'b1 && w < 3000) begin @(negedge clk_in); w++; end
        vectors++; if (d_txd !== 1'b0) begin miscompares++; $display("FAIL tx_start_timeout: got %b expected 0 within 3000 clks", d_txd); end
        lvl = 1'b0;
        // start bit and 8 data bits alternate 0,1,0,1,...,0
        for (int k = 0; k < 9; k++) begin
            vectors++; if (d_txd !== lvl) begin miscompares++; $display("FAIL tx_bit%0d_level: got %b expected %b", k, d_txd, lvl); end
            w = 0;
            while (d_txd === lvl && w < 2000) begin @(negedge clk_in); w++; end
            vectors++; if (w < 1301 || w > 1303) begin miscompares++; $display("FAIL tx_bit%0d_width: got %0d expected 1302+-1", k, w); end
            lvl = ~lvl;
        end
        vectors++; if (d_txd !== 1'b1) begin miscompares++; $display("FAIL tx_stop_level: got %b expected 1", d_txd); end
        w = 0;
        while (d_ready !== 1'b1 && w < 2000) begin @(negedge clk_in); w++; end
        vectors++; if (w < 1301 || w > 1303) begin miscompares++; $display("FAIL tx_stop_width: got %0d expected 1302+-1", w); end
        vectors++; if (d_txd !== 1'b1) begin miscompares++; $display("FAIL tx_idle_level: got %b expected 1", d_txd); end
        $display("tx: frame 0x55 observed on txd_out");
    endtask

    task automatic test_loopback();
        int w;
        @(negedge clk_in); l_data_in = 8'h41; l_send = 1'b1;
        @(negedge clk_in); l_send = 1'b0;
        w = 0;
        while (l_valid !== 1'b1 && w < 1000) begin @(negedge clk_in); w++; end
        vectors++; if (l_valid !== 1'b1) begin miscompares++; $display("FAIL lb_valid: got %b expected 1 within 1000 clks", l_valid); end
        vectors++; if (l_data_out !== 8'h41) begin miscompares++; $display("FAIL lb_data: got %h expected 41", l_data_out); end
        vectors++; if ({l_fe, l_pe, l_oe} !== 3'b000) begin miscompares++; $display("FAIL lb_errs: got %b expected 000", {l_fe, l_pe, l_oe}); end
        l_read = 1'b1; @(negedge clk_in); l_read = 1'b0;
        vectors++; if (l_valid !== 1'b0) begin miscompares++; $display("FAIL lb_read: got %b expected 0", l_valid); end
        repeat (4 * BITC) @(negedge clk_in);
        $display("loopback: 7E2 byte 0x41 received");
    endtask

    task automatic test_parity();
        sel = 1'b0;
        // 0x03 has two ones: odd parity bit should be 1, send 0
        drive_frame({5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL par_valid: got %b expected 1", o_valid); end
        vectors++; if (o_data_out !== 8'h03) begin miscompares++; $display("FAIL par_data: got %h expected 03", o_data_out); end
        vectors++; if (o_pe !== 1'b1) begin miscompares++; $display("FAIL par_err_set: got %b expected 1", o_pe); end
        vectors++; if (o_fe !== 1'b0) begin miscompares++; $display("FAIL par_no_frame: got %b expected 0", o_fe); end
        o_clr = 1'b1; o_read = 1'b1; @(negedge clk_in); o_clr = 1'b0; o_read = 1'b0;
        vectors++; if (o_pe !== 1'b0) begin miscompares++; $display("FAIL par_err_clr: got %b expected 0", o_pe); end
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL par_read: got %b expected 0", o_valid); end
        // 0x07 has three ones: correct odd parity bit is 0
        drive_frame({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        vectors++; if (o_data_out !== 8'h07) begin miscompares++; $display("FAIL par_good_data: got %h expected 07", o_data_out); end
        vectors++; if (o_pe !== 1'b0) begin miscompares++; $display("FAIL par_good_err: got %b expected 0", o_pe); end
        o_read = 1'b1; @(negedge clk_in); o_read = 1'b0;
        $display("parity: bad and good odd-parity frames received");
    endtask

    task automatic test_frame_err();
        sel = 1'b1;
        // stop bit and two further bit times held low
        drive_frame({4'b0, 2'b00, 1'b0, 8'hA5, 1'b0}, 12);
        repeat (2 * BITC) @(negedge clk_in);
        vectors++; if (f_fe !== 1'b1) begin miscompares++; $display("FAIL frm_err_set: got %b expected 1", f_fe); end
        vectors++; if (f_data_out !== 8'hA5) begin miscompares++; $display("FAIL frm_data: got %h expected a5", f_data_out); end
        vectors++; if (f_valid !== 1'b1) begin miscompares++; $display("FAIL frm_valid: got %b expected 1", f_valid); end
        f_clr = 1'b1; f_read = 1'b1; @(negedge clk_in); f_clr = 1'b0; f_read = 1'b0;
        drive_frame({5'b0, 1'b1, 8'h3C, 1'b0}, 10);
        vectors++; if (f_data_out !== 8'h3C || f_valid !== 1'b1) begin miscompares++; $display("FAIL frm_next_data: got %h/%b expected 3c/1", f_data_out, f_valid); end
        vectors++; if (f_fe !== 1'b0) begin miscompares++; $display("FAIL frm_next_err: got %b expected 0", f_fe); end
        f_read = 1'b1; @(negedge clk_in); f_read = 1'b0;
        $display("frame: break frame flagged, following frame 0x3C received");
    endtask

    task automatic test_glitch();
        sel = 1'b1;
        line = 1'b0;
        repeat (10) @(negedge clk_in);
        line = 1'b1;
        repeat (3 * BITC) @(negedge clk_in);
        vectors++; if (f_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid: got %b expected 0", f_valid); end
        vectors++; if (f_fe !== 1'b0) begin miscompares++; $display("FAIL glitch_frame: got %b expected 0", f_fe); end
        $display("glitch: 0.3-bit pulse ignored");
    endtask

    task automatic test_overrun();
        sel = 1'b1;
`ifdef UART_PARAM_RX_FIFO_EN
        for (int i = 1; i <= 5; i++)
            drive_frame({5'b0, 1'b1, 8'(i), 1'b0}, 10);
        vectors++; if (f_oe !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b expected 1", f_oe); end
        for (int i = 1; i <= 4; i++) begin
            vectors++; if (f_valid !== 1'b1 || f_data_out !== 8'(i)) begin miscompares++; $display("FAIL ovr_pop%0d: got %h/%b expected %h/1", i, f_data_out, f_valid, 8'(i)); end
            f_read = 1'b1; @(negedge clk_in); f_read = 1'b0;
        end
        vectors++; if (f_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_empty: got %b expected 0", f_valid); end
        $display("overrun: fifo kept 0x01..0x04, fifth byte dropped");
`else
        for (int i = 1; i <= 2; i++)
            drive_frame({5'b0, 1'b1, 8'(i), 1'b0}, 10);
        vectors++; if (f_oe !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b expected 1", f_oe); end
        vectors++; if (f_valid !== 1'b1 || f_data_out !== 8'h01) begin miscompares++; $display("FAIL ovr_hold: got %h/%b expected 01/1", f_data_out, f_valid); end
        f_read = 1'b1; @(negedge clk_in); f_read = 1'b0;
        vectors++; if (f_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_empty: got %b expected 0", f_valid); end
        $display("overrun: holding register kept 0x01");
`endif
    endtask

    task automatic test_reset_midframe();
        int w;
        @(negedge clk_in); l_data_in = 8'h00; l_send = 1'b1;
        @(negedge clk_in); l_send = 1'b0;
        w = 0;
        while (l_txd === 1'b1 && w < 200) begin @(negedge clk_in); w++; end
        repeat (2 * BITC) @(negedge clk_in);
        vectors++; if (l_txd !== 1'b0) begin miscompares++; $display("FAIL midrst_pre: got %b expected 0", l_txd); end
        rst_in = 1'b1;
        @(negedge clk_in);
        vectors++; if (l_txd !== 1'b1) begin miscompares++; $display("FAIL midrst_txd: got %b expected 1", l_txd); end
        vectors++; if (l_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b expected 1", l_ready); end
        rst_in = 1'b0;
        $display("reset: mid-frame abort checked");
    endtask

    initial begin
        rst_in = 1'b1; line = 1'b1; sel = 1'b1;
        d_data_in = '0; d_send = 0; d_read = 0; d_clr = 0;
        l_data_in = '0; l_send = 0; l_read = 0; l_clr = 0;
        o_read = 0; o_clr = 0; f_read = 0; f_clr = 0;
        test_reset();
        test_tx_55();
        test_loopback();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_param.md
# uart_param

Parametrised successor to the fixed 8N1 UART core. It provides a configurable frame format (5–8 data bits, none/odd/even parity, 1 or 2 stop bits) and a fractional baud generator computed from parameters. The receive path has sticky error reporting and an optional receive FIFO. It is the serial console/peripheral port on the system bus and replaces the 8N1 UART instance.

## Interface
- CLOCK_FREQ, 12_500_000: clk_in frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- DATA_BITS, 8: data bits per frame, 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- RX_FIFO_LOG2, 4: receive FIFO depth is 2**RX_FIFO_LOG2. Used only with UART_PARAM_RX_FIFO_EN.
- clk_in  in  1  system clock; the only clock.
- rst_in  in  1  reset, synchronous, active-high.
- data_in  in  8  TX byte; bits above DATA_BITS are ignored.
- send_in  in  1  TX request; accepted when tx_ready_out=1.
- tx_ready_out  out  1  TX idle, able to accept a byte.
- txd_out  out  1  serial TxD, idle high.
- rxd_in  in  1  serial RxD, asynchronous.
- data_out  out  8  head RX byte, zero-extended.
- rx_valid_out  out  1  data_out holds an unread byte.
- rx_read_in  in  1  pop the head byte; ignored when rx_valid_out=0.
- err_clr_in  in  1  clear all sticky error flags.
- frame_err_out / parity_err_out / overrun_err_out  out  1 each  sticky error flags.

## Operation
- Baud generator:
  - 16-bit phase accumulator; increment = round(BAUD_RATE*16*2^16/CLOCK_FREQ), computed at elaboration.
  - The carry out is the 16x sample tick (1 clk wide).
  - An elaboration-time error is raised if the increment is 0 or ≥2^16.
- RX input passes through a 2-flop synchroniser before any use.
- RX FSM, one-hot: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a low sample on a tick records phase offset = count+8, then goes to START.
  - START: at mid-bit, high → IDLE (glitch rejected); low → DATA.
  - DATA: one bit at each mid-bit tick, LSB first; after DATA_BITS bits go to PARITY if PARITY≠0, otherwise to STOP.
  - PARITY: compare the sampled bit with the computed parity; a mismatch sets parity_err.
  - STOP: sample only the first stop bit. Low sets frame_err and the byte is still delivered; the FSM waits in STOP until rxd is high, then goes to IDLE. High delivers the byte and goes to IDLE.
- TX FSM: IDLE, START, DATA, PARITY, STOP.
  - send_in & tx_ready_out latches data_in and drops tx_ready_out on the next edge.
  - Bit boundaries come from a divide-by-16 of the sample tick.
  - Frame order: start bit (0), data LSB first, parity if enabled, STOP_BITS ones.
  - tx_ready_out rises when the last stop bit period ends.
- Error flags:
  - A flag is set by its event and cleared by err_clr_in.
  - If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: txd_out=1, tx_ready_out=1, rx_valid_out=0, data_out=0, all error flags 0. Accumulator, FSMs and FIFO pointers are also cleared.
- Reset asserted mid-frame aborts the frame immediately. txd_out returns to 1 on the next edge.
- TX latency: start bit begins at the first bit tick after acceptance, within 1 bit time plus 1 clk.
- RX latency: rx_valid_out rises 1 clk after the stop-bit mid-sample.
- rx_read_in with rx_valid_out=1 consumes the byte on that edge. The next byte, if any, is visible the following cycle.
- A frame lasts 1+DATA_BITS+(PARITY≠0)+STOP_BITS bit times.

## Configuration
- UART_PARAM_RX_FIFO_EN defined:
  - Received bytes go through a 2**RX_FIFO_LOG2-entry FIFO; data_out is the FIFO head.
  - Full FIFO and a new byte with no pop in the same cycle: the new byte is dropped and overrun is set.
  - Full FIFO with push and pop in the same cycle: both happen, no overrun.
  - Pop on empty is ignored.
  - Pointers are RX_FIFO_LOG2+1 bits wide and wrap naturally.
- UART_PARAM_RX_FIFO_EN undefined:
  - A single holding register replaces the FIFO.
  - New byte while rx_valid_out=1 and no rx_read_in: the old byte is kept, the new byte is discarded, overrun is set.
  - New byte coincident with rx_read_in: the new byte replaces the old one, no overrun.

## Structure
- Shared package/include uart_pkg holds:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - RX and TX state index constants;
  - SAMPLE_BITS=4;
  - ACC_BITS=16;
  - the baud-increment function.
- Sub-module uart_param_fifo: synchronous FIFO with depth and width parameters, instantiated only under the macro.
- The baud generator, RX FSM and TX FSM stay in uart_param.

## Test plan
- Defaults, send_in with 0x55 → txd_out carries 0,1,0,1,0,1,0,1,0,1, each 1302±1 clks wide; tx_ready_out is low for 10 bit times.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2: loop txd_out to rxd_in and send 0x41 → data_out=0x41, rx_valid_out=1, no errors.
- PARITY=1 (odd): drive a frame with a wrong parity bit → parity_err_out=1 and the byte is delivered; err_clr_in → 0.
- Hold rxd_in low through the stop bit → frame_err_out=1; rxd_in back high → the next frame is received normally.
- 0.3-bit low glitch on idle rxd_in → no byte, rx_valid_out stays 0.
- FIFO on, RX_FIFO_LOG2=2: receive 5 bytes 0x01..0x05 without reading → 0x01..0x04 read back in order and overrun_err_out=1. Macro off: 2 bytes unread → data_out=0x01, overrun set.
